// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Sequences the PC, issues one
//                outstanding request at a time to instruction memory, buffers
//                returned instructions in a small FIFO and hands them to the
//                decoder over a ready/valid handshake. Supports redirects and
//                a sticky halt that only reset clears.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                  PC_WIDTH = 8,
  parameter int                  DEPTH    = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                n_rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic                imem_rvalid,
  input  logic [7:0]          imem_rdata,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                halt,
  output logic                out_valid,
  output logic [7:0]          out_instr,
  output logic [PC_WIDTH-1:0] out_pc,
  input  logic                out_ready,
  output logic                halted
);

  // Pointer width indexes DEPTH entries; the count needs one extra bit to
  // represent "full".
  localparam int                  c_AW      = $clog2(DEPTH);
  localparam int                  c_CW      = c_AW + 1;
  localparam logic [c_CW-1:0]     c_DEPTH   = c_CW'(DEPTH);
  localparam logic [c_CW-1:0]     c_CNT_ONE = c_CW'(1);
  localparam logic [c_AW-1:0]     c_PTR_ONE = c_AW'(1);
  localparam logic [PC_WIDTH-1:0] c_PC_ONE  = PC_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_req_pc;
  logic                r_halt_pend;

  logic [7:0]          r_instr_mem [DEPTH];
  logic [PC_WIDTH-1:0] r_pc_mem    [DEPTH];
  logic [c_AW-1:0]     r_rd_ptr;
  logic [c_AW-1:0]     r_wr_ptr;
  logic [c_CW-1:0]     r_count;

  logic w_is_halted;
  logic w_halt;
  logic w_redir;
  logic w_flush;
  logic w_req;
  logic w_accept;
  logic w_push;
  logic w_out_valid;
  logic w_pop;

  // Once halted, redirect and halt are ignored. Halt beats a simultaneous
  // redirect, so the redirect is qualified by !halt.
  assign w_is_halted = (r_state == ST_HALTED);
  assign w_halt      = halt && !w_is_halted;
  assign w_redir     = redirect && !w_is_halted && !halt;
  assign w_flush     = w_halt || w_redir;

  // Requests only from RUN with room in the buffer; never in a cycle that is
  // about to change the PC. Gated by reset so every output reads 0 in reset.
  assign w_req    = n_rst && (r_state == ST_RUN) && !r_halt_pend &&
                    (r_count < c_DEPTH) && !redirect && !halt;
  assign w_accept = w_req && imem_ready;

  // A response is kept only when it answers a live request (WAIT) and the
  // same cycle is not flushing the buffer.
  assign w_push = (r_state == ST_WAIT) && imem_rvalid && !w_flush;

  assign w_out_valid = (r_count != '0) && !r_halt_pend && !w_is_halted;
  assign w_pop       = w_out_valid && out_ready;

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign out_valid = w_out_valid;
  assign out_instr = r_instr_mem[r_rd_ptr];
  assign out_pc    = r_pc_mem[r_rd_ptr];
  assign halted    = w_is_halted;

  // Fetch sequencer: PC, request tracking, halt latch and state transitions.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_PC;
      r_req_pc    <= RESET_PC;
      r_halt_pend <= 1'b0;
    end else begin
      if (w_halt) begin
        r_halt_pend <= 1'b1;
      end
      if (w_redir) begin
        r_pc <= redirect_pc;
      end
      case (r_state)
        ST_RUN: begin
          if (r_halt_pend || w_halt) begin
            r_state <= ST_HALTED;
          end else if (w_accept) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + c_PC_ONE;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A response coincident with halt/redirect completes the request
          // (and is dropped), so there is nothing left to drain.
          if (imem_rvalid) begin
            r_state <= (r_halt_pend || w_halt) ? ST_HALTED : ST_RUN;
          end else if (w_halt || w_redir) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (imem_rvalid) begin
            r_state <= (r_halt_pend || w_halt) ? ST_HALTED : ST_RUN;
          end
        end
        ST_HALTED: begin
          r_state <= ST_HALTED;
        end
      endcase
    end
  end

  // Instruction buffer: circular FIFO; flush overrides any push or pop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr_mem[i] <= '0;
        r_pc_mem[i]    <= '0;
      end
    end else if (w_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_instr_mem[r_wr_ptr] <= imem_rdata;
        r_pc_mem[r_wr_ptr]    <= r_req_pc;
        r_wr_ptr              <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A memory model returns
//                addr^8'h5A after a configurable latency; the expected
//                decoder stream is the consecutive PC sequence starting at
//                the last reset/redirect target, held in a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic       clk;
  logic       n_rst;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ready;
  logic       imem_rvalid;
  logic [7:0] imem_rdata;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       halt;
  logic       out_valid;
  logic [7:0] out_instr;
  logic [7:0] out_pc;
  logic       out_ready;
  logic       halted;

  fetch_unit #(.PC_WIDTH(8), .DEPTH(2), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_ready   (out_ready),
    .halted      (halted)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  int         hs_cnt = 0;
  logic [7:0] exp_q[$];
  bit         halt_exp = 0;

  // memory model controls and state
  int         lat_cfg   = 1;
  bit         rand_lat  = 0;
  bit         mem_block = 0;
  int         ready_pct = 100;
  bit         mem_pend  = 0;
  logic [7:0] pend_addr;
  int         wait_cnt;
  bit         m_acc;
  logic [7:0] m_addr;
  int         m_lat;

  // hold-check state
  bit         prev_wait = 0;
  logic [7:0] prev_addr;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Instruction memory: single outstanding request, data = addr ^ 8'h5A.
  initial begin
    imem_ready  = 1;
    imem_rvalid = 0;
    imem_rdata  = 0;
    forever begin
      @(negedge clk);
      m_acc  = n_rst && imem_req && imem_ready;
      m_addr = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = 0;
      if (mem_pend) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          imem_rvalid = 1;
          imem_rdata  = pend_addr ^ 8'h5A;
          mem_pend    = 0;
        end
      end
      if (m_acc) begin
        m_lat = rand_lat ? int'($urandom_range(1, 3)) : lat_cfg;
        if (m_lat <= 1) begin
          imem_rvalid = 1;
          imem_rdata  = m_addr ^ 8'h5A;
        end else begin
          mem_pend  = 1;
          pend_addr = m_addr;
          wait_cnt  = m_lat - 1;
        end
      end
      imem_ready = !mem_block && (int'($urandom_range(0, 99)) < ready_pct);
    end
  end

  // Monitor: scoreboard pop on every decoder handshake, plus protocol checks.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (n_rst && out_valid && out_ready) begin
        hs_cnt++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL handshake: got pc=%h instr=%h, required no output", out_pc, out_instr);
        end else begin
          e = exp_q.pop_front();
          if (out_pc !== e || out_instr !== (e ^ 8'h5A)) begin
            n_err++;
            $display("FAIL stream: got pc=%h instr=%h, required pc=%h instr=%h",
                     out_pc, out_instr, e, e ^ 8'h5A);
          end
        end
      end
      if (halt_exp) begin
        n_vec++;
        if (imem_req !== 1'b0) begin
          n_err++;
          $display("FAIL halted_req: got imem_req=%b, required 0", imem_req);
        end
      end
      if (n_rst && prev_wait && imem_req) begin
        n_vec++;
        if (imem_addr !== prev_addr) begin
          n_err++;
          $display("FAIL addr_hold: got %h, required %h", imem_addr, prev_addr);
        end
      end
      prev_wait = n_rst && imem_req && !imem_ready;
      prev_addr = imem_addr;
    end
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic restart_stream(input logic [7:0] pc);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(int'(pc) + i));
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return mem_pend;
      1:       return !mem_pend;
      2:       return out_valid && mem_pend;
      default: return !imem_rvalid;
    endcase
  endfunction

  task automatic wait_for(input string what, input int which, input int maxc);
    bit ok = 0;
    for (int i = 0; i < maxc; i++) begin
      if (cond(which)) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) ok = cond(which);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL timeout %s: got no event in %0d cycles, required event", what, maxc);
    end
  endtask

  task automatic pulse_redirect(input logic [7:0] pc);
    redirect    = 1;
    redirect_pc = pc;
    tick();
    redirect = 0;
    restart_stream(pc);
  endtask

  // Reset is asserted between edges; outputs are checked before any clock.
  task automatic reset_dut();
    n_rst = 0;
    #1;
    check("rst_imem_req", 32'(imem_req), 0);
    check("rst_imem_addr", 32'(imem_addr), 32'h00);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_instr", 32'(out_instr), 0);
    check("rst_out_pc", 32'(out_pc), 0);
    check("rst_halted", 32'(halted), 0);
    tick();
    tick();
    n_rst = 1;
    restart_stream(8'h00);
  endtask

  initial begin
    int hs_cyc[$];
    int hs0;
    n_rst       = 1;
    redirect    = 0;
    redirect_pc = 0;
    halt        = 0;
    out_ready   = 1;
    #3;
    reset_dut();

    // sequential fetch, 1-cycle memory: one instruction every 2 cycles
    for (int i = 0; i < 40 && hs_cyc.size() < 6; i++) begin
      tick();
      if (out_valid && out_ready) hs_cyc.push_back(cyc);
    end
    check("seq_count", 32'(hs_cyc.size()), 6);
    for (int i = 1; i < hs_cyc.size(); i++)
      check("seq_gap", 32'(hs_cyc[i] - hs_cyc[i-1]), 2);

    // back-pressure: buffer fills to DEPTH, requests stop
    out_ready = 0;
    for (int i = 0; i < 10; i++) tick();
    check("full_req", 32'(imem_req), 0);
    check("full_valid", 32'(out_valid), 1);
    out_ready = 1;
    tick();
    check("full_second_entry", 32'(out_valid), 1);
    for (int i = 0; i < 6; i++) tick();

    // redirect while a 3-cycle response is outstanding
    lat_cfg = 3;
    wait_for("outstanding", 0, 20);
    pulse_redirect(8'h40);
    check("redir_flush", 32'(out_valid), 0);
    hs0 = hs_cnt;
    for (int i = 0; i < 30; i++) tick();
    check("redir_progress", 32'(hs_cnt - hs0 >= 3), 1);

    // PC wrap
    lat_cfg = 1;
    wait_for("no_rvalid", 3, 10);
    pulse_redirect(8'hFF);
    hs0 = hs_cnt;
    for (int i = 0; i < 12; i++) tick();
    check("wrap_progress", 32'(hs_cnt - hs0 >= 3), 1);

    // randomized traffic with occasional redirects
    rand_lat  = 1;
    ready_pct = 70;
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0 && !imem_rvalid)
        pulse_redirect(8'($urandom_range(0, 255)));
      else
        tick();
    end
    rand_lat  = 0;
    ready_pct = 100;

    // halt with one outstanding request and one buffered entry
    out_ready = 0;
    lat_cfg   = 3;
    wait_for("no_rvalid", 3, 10);
    pulse_redirect(8'h10);
    wait_for("buffered_and_pending", 2, 60);
    halt = 1;
    tick();
    halt = 0;
    exp_q.delete();
    halt_exp = 1;
    check("halt_valid_drop", 32'(out_valid), 0);
    wait_for("drain", 1, 20);
    for (int i = 0; i < 3; i++) tick();
    check("halt_halted", 32'(halted), 1);
    check("halt_req", 32'(imem_req), 0);
    out_ready   = 1;
    redirect    = 1;
    redirect_pc = 8'h33;
    tick();
    redirect = 0;
    tick();
    check("halt_redir_ignored", 32'(halted), 1);
    check("halt_no_valid", 32'(out_valid), 0);
    halt_exp = 0;

    // reset exits HALTED, then reset again while a request is outstanding
    reset_dut();
    check("post_rst_halted", 32'(halted), 0);
    lat_cfg = 6;
    wait_for("outstanding_long", 0, 20);
    mem_block = 1;
    reset_dut();
    wait_for("late_response", 1, 20);
    mem_block = 0;
    lat_cfg   = 1;
    hs0 = hs_cnt;
    for (int i = 0; i < 20; i++) tick();
    check("restart_progress", 32'(hs_cnt - hs0 >= 5), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decoder; supplies its 8-bit instruction and valid.
- Sequences the PC, issues single-outstanding requests to instruction memory, buffers returned instructions in a small FIFO, and presents them to the decoder with a ready/valid handshake.
- Accepts redirects (jump/branch/interrupt target) from the branch controller, and a halt from the decoded HLT instruction.

Parameters:
- PC_WIDTH, 8, width of the PC and the memory address.
- DEPTH, 2, instruction buffer entries (power of two, at least 2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- n_rst  in  1  asynchronous active-low reset.
- imem_req  out  1  request valid.
- imem_addr  out  PC_WIDTH  request address; equals the current PC.
- imem_ready  in  1  memory accepts the request when imem_req && imem_ready.
- imem_rvalid  in  1  response valid; never asserted in the same cycle as acceptance (latency is at least 1).
- imem_rdata  in  8  returned instruction.
- redirect  in  1  single-cycle pulse that changes the PC.
- redirect_pc  in  PC_WIDTH  new PC.
- halt  in  1  single-cycle pulse; stop fetching.
- out_valid  out  1  decoder valid.
- out_instr  out  8  decoder instruction.
- out_pc  out  PC_WIDTH  address of out_instr; the branch controller uses it for JRL link.
- out_ready  in  1  decoder accepts when out_valid && out_ready.
- halted  out  1  high in HALTED.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low, clock port clk, reset port n_rst.
- Reset values: pc=RESET_PC, FIFO empty, state=RUN, halt_pend=0. All outputs are 0 except imem_addr=RESET_PC.
- States: RUN, WAIT, DRAIN, HALTED.
- RUN:
  - imem_req = !halt_pend && count<DEPTH && !redirect && !halt.
  - On acceptance: latch req_pc=pc, set pc<=pc+1 (wraps modulo 2^PC_WIDTH), go to WAIT.
  - If halt_pend is set, go to HALTED.
- WAIT:
  - imem_req=0.
  - On imem_rvalid: push {imem_rdata, req_pc}, then go to RUN, or to HALTED if halt_pend.
  - Peak throughput is 1 instruction per 2 cycles. This is the decided rate.
- DRAIN: an outstanding response is stale. On imem_rvalid, discard it and go to RUN, or to HALTED if halt_pend.
- HALTED: imem_req=0, out_valid=0, halted=1. Only reset exits this state. redirect and halt are ignored.
- Redirect (any state except HALTED):
  - Flush the FIFO (count=0) that cycle and set pc<=redirect_pc.
  - In RUN, no request is issued in the redirect cycle, so the next state is RUN.
  - In WAIT without rvalid, go to DRAIN.
  - In WAIT with rvalid in the same cycle, drop the response and go to RUN.
  - In DRAIN, stay in DRAIN.
- Halt: flush the FIFO and set halt_pend=1.
  - From RUN, go to HALTED next cycle.
  - From WAIT, go to DRAIN; the response is discarded, then go to HALTED.
  - If halt and redirect arrive in the same cycle, halt wins and the PC is not updated.
- Output:
  - out_valid = count!=0 && !halt_pend && state!=HALTED.
  - out_instr and out_pc come from the FIFO head.
  - Pop on out_valid && out_ready.
- Simultaneous push and pop: count is unchanged and ordering is preserved.
- Flush versus pop/push in the same cycle: flush wins and the FIFO ends empty.
- Overflow is impossible: issue requires count<DEPTH and only one request is outstanding. The verifier asserts that a push never occurs when count==DEPTH, and that a pop never occurs when empty.
- Reset mid-operation (including in WAIT): return to the reset state immediately. A late imem_rvalid arriving in RUN is ignored.
- imem_addr holds its value while imem_req is high and not yet accepted.

Test Plan:
- Reset, memory with 1-cycle latency returning addr^8'h5A, out_ready=1 → out_instr sequence 5A,5B,58,… with out_pc 0,1,2; one instruction every 2 cycles.
- out_ready=0 for 10 cycles → exactly 2 entries buffered, imem_req low once full. Release → pc order preserved, nothing lost or duplicated.
- redirect_pc=8'h40 while in WAIT (response arrives 3 cycles later) → stale response dropped, FIFO empty. Next out_pc=8'h40 with instruction from 8'h40.
- PC_WIDTH=8, start via redirect to 8'hFF → out_pc FF then 00 (wrap).
- halt pulse with one outstanding and 1 buffered entry → out_valid falls the next cycle, response discarded, halted=1, no further imem_req. A later redirect has no effect.
- Assert n_rst low in WAIT → all outputs 0 asynchronously, imem_addr=RESET_PC. After release, fetch restarts at RESET_PC.
